// File: rtl/sim_exit_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sim_exit_writer
//  Description : Simulation-exit reporter. Takes one exit code over a
//                valid/ready handshake, enforces an optional cycle budget,
//                waits a drain window so logs can flush, then raises sticky
//                done/pass/timeout status. Outside SYNTHESIS it prints the
//                verdict on entering DONE and can end the run.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_exit_writer #(
   parameter int              CODE_WIDTH   = 32,
   parameter int              CNT_WIDTH    = 64,
   parameter longint unsigned MAX_CYCLES   = 0,
   parameter int              DRAIN_CYCLES = 16,
   parameter int              FINISH       = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  exit_valid,
   output logic                  exit_ready,
   input  logic [CODE_WIDTH-1:0] exit_code,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [CODE_WIDTH-1:0] final_code,
   output logic [CNT_WIDTH-1:0]  cycle_count
);

   // Drain counter only needs to hold DRAIN_CYCLES; keep at least one bit.
   localparam int                   c_DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [c_DW-1:0]      c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES);
   localparam logic [c_DW-1:0]      c_DRAIN_ONE  = c_DW'(1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

   // The budget fires when the counter reads MAX_CYCLES-1. If that value
   // cannot be represented in CNT_WIDTH bits the counter saturates first and
   // the budget can never expire, so the check is disabled rather than
   // comparing against a truncated value.
   localparam longint unsigned      c_LAST       = MAX_CYCLES - 64'd1;
   localparam bit                   c_TO_EN      = (MAX_CYCLES != 0) && ((c_LAST >> CNT_WIDTH) == 0);
   localparam logic [CNT_WIDTH-1:0] c_TO_AT      = CNT_WIDTH'(c_LAST);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_DW-1:0]        r_drain;
   logic [CNT_WIDTH-1:0]   r_cycle_count;
   logic                   r_ready;
   logic                   r_done;
   logic                   r_pass;
   logic                   r_timeout;
   logic [CODE_WIDTH-1:0]  r_final_code;

   logic                   w_handshake;
   logic                   w_budget_hit;

   // r_ready is high exactly in RUN, so it never depends on exit_valid.
   assign w_handshake  = exit_valid && r_ready;
   assign w_budget_hit = c_TO_EN && (r_cycle_count == c_TO_AT);

   // Exit FSM with registered status outputs and the saturating cycle counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_RUN;
         r_drain       <= '0;
         r_cycle_count <= '0;
         r_ready       <= 1'b1;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_timeout     <= 1'b0;
         r_final_code  <= '0;
      end else begin
         // Counter runs until DONE and sticks at all-ones if it ever gets there.
         if ((r_state != S_DONE) && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + c_CNT_ONE;
         end

         case (r_state)
            S_RUN: begin
               // The handshake is checked first so it wins a same-cycle
               // collision with the budget expiring.
               if (w_handshake) begin
                  r_final_code <= exit_code;
                  r_pass       <= (exit_code == '0);
                  r_timeout    <= 1'b0;
                  r_drain      <= c_DRAIN_LOAD;
                  r_ready      <= 1'b0;
                  r_state      <= S_DRAIN;
               end else if (w_budget_hit) begin
                  r_final_code <= '1;
                  r_pass       <= 1'b0;
                  r_timeout    <= 1'b1;
                  r_drain      <= c_DRAIN_LOAD;
                  r_ready      <= 1'b0;
                  r_state      <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               // exit_valid is ignored here; just count the drain window out.
               if (r_drain == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_drain <= r_drain - c_DRAIN_ONE;
               end
            end

            S_DONE: begin
               // Everything holds until reset.
            end

            default: begin
               // Unreachable encoding: park in DONE rather than re-arm.
               r_ready <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign exit_ready  = r_ready;
   assign done        = r_done;
   assign pass        = r_pass;
   assign timeout     = r_timeout;
   assign final_code  = r_final_code;
   assign cycle_count = r_cycle_count;

`ifndef SYNTHESIS
   // Report the verdict once, on the edge that moves DRAIN into DONE.
   always_ff @(posedge clock) begin
      if (!reset && (r_state == S_DRAIN) && (r_drain == '0)) begin
         if (r_timeout) begin
            $display("*** TIMEOUT *** after %0d cycles", MAX_CYCLES);
         end else if (r_pass) begin
            $display("*** PASSED ***");
         end else begin
            $display("*** FAILED *** code=%0d", r_final_code);
         end
         if (FINISH != 0) begin
            $finish;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_exit_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_exit_writer
//  Description : Self-checking bench for sim_exit_writer. Several instances
//                with different parameters are each compared cycle by cycle
//                against a latency-rule model of the exit reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_exit_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   localparam int              NEVER = 1 << 30;
   localparam longint unsigned SAT64 = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic        ready;
      logic        done;
      logic        pass;
      logic        tmo;
      logic [31:0] code;
      logic [63:0] cnt;
   } obs_t;

   // p: MAX=0 D=4 | z: MAX=0 D=0 | t: MAX=100 D=4 | k: MAX=50 D=4
   // s: CNT=4 MAX=0 D=4 | q: MAX=40 D=3 (random runs)
   logic p_rst = 1'b1, p_valid = 1'b0; logic [31:0] p_code = '0;
   logic p_ready, p_done, p_pass, p_tmo; logic [31:0] p_fcode; logic [63:0] p_cnt;
   logic z_rst = 1'b1, z_valid = 1'b0; logic [31:0] z_code = '0;
   logic z_ready, z_done, z_pass, z_tmo; logic [31:0] z_fcode; logic [63:0] z_cnt;
   logic t_rst = 1'b1, t_valid = 1'b0; logic [31:0] t_code = '0;
   logic t_ready, t_done, t_pass, t_tmo; logic [31:0] t_fcode; logic [63:0] t_cnt;
   logic k_rst = 1'b1, k_valid = 1'b0; logic [31:0] k_code = '0;
   logic k_ready, k_done, k_pass, k_tmo; logic [31:0] k_fcode; logic [63:0] k_cnt;
   logic s_rst = 1'b1, s_valid = 1'b0; logic [31:0] s_code = '0;
   logic s_ready, s_done, s_pass, s_tmo; logic [31:0] s_fcode; logic [3:0] s_cnt;
   logic q_rst = 1'b1, q_valid = 1'b0; logic [31:0] q_code = '0;
   logic q_ready, q_done, q_pass, q_tmo; logic [31:0] q_fcode; logic [63:0] q_cnt;

   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(64), .MAX_CYCLES(0), .DRAIN_CYCLES(4), .FINISH(0)) u_p (
      .clock(clk), .reset(p_rst), .exit_valid(p_valid), .exit_ready(p_ready), .exit_code(p_code),
      .done(p_done), .pass(p_pass), .timeout(p_tmo), .final_code(p_fcode), .cycle_count(p_cnt));
   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(64), .MAX_CYCLES(0), .DRAIN_CYCLES(0), .FINISH(0)) u_z (
      .clock(clk), .reset(z_rst), .exit_valid(z_valid), .exit_ready(z_ready), .exit_code(z_code),
      .done(z_done), .pass(z_pass), .timeout(z_tmo), .final_code(z_fcode), .cycle_count(z_cnt));
   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(64), .MAX_CYCLES(100), .DRAIN_CYCLES(4), .FINISH(0)) u_t (
      .clock(clk), .reset(t_rst), .exit_valid(t_valid), .exit_ready(t_ready), .exit_code(t_code),
      .done(t_done), .pass(t_pass), .timeout(t_tmo), .final_code(t_fcode), .cycle_count(t_cnt));
   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(64), .MAX_CYCLES(50), .DRAIN_CYCLES(4), .FINISH(0)) u_k (
      .clock(clk), .reset(k_rst), .exit_valid(k_valid), .exit_ready(k_ready), .exit_code(k_code),
      .done(k_done), .pass(k_pass), .timeout(k_tmo), .final_code(k_fcode), .cycle_count(k_cnt));
   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(4), .MAX_CYCLES(0), .DRAIN_CYCLES(4), .FINISH(0)) u_s (
      .clock(clk), .reset(s_rst), .exit_valid(s_valid), .exit_ready(s_ready), .exit_code(s_code),
      .done(s_done), .pass(s_pass), .timeout(s_tmo), .final_code(s_fcode), .cycle_count(s_cnt));
   sim_exit_writer #(.CODE_WIDTH(32), .CNT_WIDTH(64), .MAX_CYCLES(40), .DRAIN_CYCLES(3), .FINISH(0)) u_q (
      .clock(clk), .reset(q_rst), .exit_valid(q_valid), .exit_ready(q_ready), .exit_code(q_code),
      .done(q_done), .pass(q_pass), .timeout(q_tmo), .final_code(q_fcode), .cycle_count(q_cnt));

   // Expected outputs in cycle c for an exit event (handshake or budget) in
   // cycle ev with a drain window of d: status appears at ev+1, done at
   // ev+d+2, the counter follows c until done and is capped at sat.
   function automatic obs_t model(int c, int ev, int d, bit tmo, logic [31:0] code,
                                  longint unsigned sat);
      obs_t            m;
      int              done_at;
      longint unsigned n;
      done_at = ev + d + 2;
      m.ready = (c <= ev);
      m.pass  = (c > ev) && !tmo && (code == 32'h0);
      m.tmo   = (c > ev) && tmo;
      m.code  = (c > ev) ? (tmo ? 32'hFFFF_FFFF : code) : 32'h0;
      m.done  = (c >= done_at);
      n       = (c < done_at) ? longint'(c) : longint'(done_at);
      if (n > sat) n = sat;
      m.cnt   = n;
      return m;
   endfunction

   function automatic string fmt(obs_t x);
      return $sformatf("rdy=%b done=%b pass=%b tmo=%b code=%h cnt=%0d",
                       x.ready, x.done, x.pass, x.tmo, x.code, x.cnt);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      p_rst = 1'b1; s_rst = 1'b1; p_valid = 1'b0; s_valid = 1'b0;
      step();
      p_rst = 1'b0; s_rst = 1'b0;
      e = model(0, NEVER, 4, 1'b0, 32'h0, SAT64);
      o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
      n_total++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL reset_p got %s want %s", fmt(o), fmt(e));
      end
      o = {s_ready, s_done, s_pass, s_tmo, s_fcode, 60'h0, s_cnt};
      n_total++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL reset_s got %s want %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_pass();
      obs_t e, o;
      p_rst = 1'b1; p_valid = 1'b0; p_code = '0;
      step();
      p_rst = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         e = model(c, 10, 4, 1'b0, 32'h0, SAT64);
         o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL pass c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         p_valid = (c == 10);
         step();
      end
      p_valid = 1'b0;
   endtask

   // Nonzero code with no drain: checked up to the latch, then reset before
   // DONE; a zero code then confirms done lands two cycles after the event.
   task automatic test_fail_code();
      obs_t e, o;
      z_rst = 1'b1; z_valid = 1'b0;
      step();
      z_rst = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         e = model(c, 5, 0, 1'b0, 32'h2A, SAT64);
         o = {z_ready, z_done, z_pass, z_tmo, z_fcode, z_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL fail_code c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         z_valid = (c == 5);
         z_code  = (c == 5) ? 32'h2A : 32'h0;
         if (c < 6) step();
      end
      z_rst = 1'b1;
      step();
      z_rst = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         e = model(c, 3, 0, 1'b0, 32'h0, SAT64);
         o = {z_ready, z_done, z_pass, z_tmo, z_fcode, z_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL drain0_pass c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         z_valid = (c == 3);
         z_code  = 32'h0;
         step();
      end
      z_valid = 1'b0;
   endtask

   task automatic test_timeout();
      obs_t e, o;
      t_rst = 1'b1; t_valid = 1'b0;
      step();
      t_rst = 1'b0;
      for (int c = 0; c <= 110; c++) begin
         e = model(c, 99, 4, 1'b1, 32'h0, SAT64);
         o = {t_ready, t_done, t_pass, t_tmo, t_fcode, t_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL timeout c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         step();
      end
   endtask

   // Handshake in the budget's last cycle, then a stray pulse during DRAIN.
   task automatic test_collision();
      obs_t e, o;
      k_rst = 1'b1; k_valid = 1'b0;
      step();
      k_rst = 1'b0;
      for (int c = 0; c <= 60; c++) begin
         e = model(c, 49, 4, 1'b0, 32'h0, SAT64);
         o = {k_ready, k_done, k_pass, k_tmo, k_fcode, k_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL collision c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         k_valid = (c == 49) || (c == 52);
         k_code  = (c == 52) ? 32'h7 : 32'h0;
         step();
      end
      k_valid = 1'b0;
   endtask

   task automatic test_reset_midrun();
      obs_t e, o, r;
      r = model(0, NEVER, 4, 1'b0, 32'h0, SAT64);
      p_rst = 1'b1; p_valid = 1'b0;
      step();
      p_rst = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         e = model(c, 3, 4, 1'b0, 32'h55, SAT64);
         o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL midrun_drain c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         p_valid = (c == 3);
         p_code  = 32'h55;
         if (c < 6) step();
      end
      p_valid = 1'b0; p_rst = 1'b1;
      step();
      p_rst = 1'b0;
      o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
      n_total++;
      if (o !== r) begin
         n_bad++;
         $display("FAIL reset_in_drain got %s want %s", fmt(o), fmt(r));
      end
      for (int c = 0; c <= 10; c++) begin
         e = model(c, 2, 4, 1'b0, 32'h0, SAT64);
         o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL midrun_done c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         p_valid = (c == 2);
         p_code  = 32'h0;
         if (c < 10) step();
      end
      p_valid = 1'b0; p_rst = 1'b1;
      step();
      p_rst = 1'b0;
      o = {p_ready, p_done, p_pass, p_tmo, p_fcode, p_cnt};
      n_total++;
      if (o !== r) begin
         n_bad++;
         $display("FAIL reset_in_done got %s want %s", fmt(o), fmt(r));
      end
   endtask

   task automatic test_saturation();
      obs_t e, o;
      s_rst = 1'b1; s_valid = 1'b0;
      step();
      s_rst = 1'b0;
      for (int c = 0; c <= 25; c++) begin
         e = model(c, NEVER, 4, 1'b0, 32'h0, 64'd15);
         o = {s_ready, s_done, s_pass, s_tmo, s_fcode, 60'h0, s_cnt};
         n_total++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL saturation c=%0d got %s want %s", c, fmt(o), fmt(e));
         end
         step();
      end
   endtask

   // Random arrival cycle and code against a 40-cycle budget. A nonzero code
   // that is accepted is reset on its last drain cycle, before DONE.
   task automatic test_random();
      obs_t        e, o;
      int          n, ev, last;
      bit          hs;
      logic [31:0] code;
      for (int it = 0; it < 12; it++) begin
         n    = int'($urandom_range(0, 45));
         code = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom | 32'h1);
         hs   = (n <= 39);
         ev   = hs ? n : 39;
         last = (hs && code != 32'h0) ? ev + 4 : ev + 7;
         q_rst = 1'b1; q_valid = 1'b0;
         step();
         q_rst = 1'b0;
         for (int c = 0; c <= last; c++) begin
            e = model(c, ev, 3, !hs, code, SAT64);
            o = {q_ready, q_done, q_pass, q_tmo, q_fcode, q_cnt};
            n_total++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL random it=%0d n=%0d c=%0d got %s want %s", it, n, c, fmt(o), fmt(e));
            end
            q_valid = (c >= n);
            q_code  = code;
            if (c < last) step();
         end
         q_valid = 1'b0;
      end
      q_rst = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail_code();
      test_timeout();
      test_collision();
      test_reset_midrun();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
